// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the sequencer state encoding used by
// alu_share_arb and its testbench.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_DIV = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone request wins outright; on a tie the
// requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two valid/ready requesters:
// round-robin grant, operand latch, one execute cycle, held response.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [CTRL_W-1:0] req_ctrl1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              last_grant;
    logic              owner;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              err_q;
    logic [1:0]        gnt;
    logic              handshake;
    logic              div_trap;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign div_trap = (ctrl_q == CTRL_W'(ALU_DIV)) && (b_q == '0);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        handshake  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = gnt;
                handshake = |(req_valid & gnt);
                if (handshake) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (handshake) begin
                owner      <= gnt[1];
                last_grant <= gnt[1];
                a_q        <= gnt[1] ? req_a1    : req_a0;
                b_q        <= gnt[1] ? req_b1    : req_b0;
                ctrl_q     <= gnt[1] ? req_ctrl1 : req_ctrl0;
            end
            // A divide by zero overrides whatever the ALU produced.
            if (state == ST_EXEC) begin
                res_q  <= div_trap ? '1   : alu_result;
                zero_q <= div_trap ? 1'b0 : alu_zero;
                err_q  <= div_trap;
            end
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: behavioural ALU at the parent level,
// transaction scoreboard with a grant/latency model, directed and random traffic.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_ctrl0 = '0, req_ctrl1 = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_result;
    logic        resp_zero, resp_err;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_ctrl0   (req_ctrl0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_ctrl1   (req_ctrl1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Behavioural ALU; shift amount sits in b[10:6], SLT is unsigned.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[10:6];
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_XOR: return a ^ b;
            ALU_MUL: return a * b;
            ALU_SUB: return a - b;
            ALU_SLT: return {31'd0, (a < b)};
            ALU_SLL: return a << sh;
            ALU_SRL: return a >> sh;
            ALU_SRA: return $unsigned($signed(a) >>> sh);
            ALU_DIV: return (b == 32'd0) ? 32'd0 : a / b;
            ALU_NOR: return ~(a | b);
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
    end

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } op_t;

    op_t q0[$];
    op_t q1[$];
    op_t inflight;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard / model state
    bit          busy;
    bit          last_m;
    int          owner_m;
    int          hs_cyc;
    int          cyc_now;
    int          rsp_cnt;
    bit          resp_seen;
    logic [1:0]  drop;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_ctrl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] res, input logic zero, input logic err);
        op_t o;
        o.ctrl = c; o.a = a; o.b = b; o.res = res; o.zero = zero; o.err = err;
        return o;
    endfunction

    function automatic op_t ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (c == ALU_DIV && b == 32'd0) return mk_op(c, a, b, 32'hFFFF_FFFF, 1'b0, 1'b1);
        r = alu_fn(c, a, b);
        return mk_op(c, a, b, r, (r == 32'd0), 1'b0);
    endfunction

    function automatic op_t rand_op();
        logic [3:0]  c;
        logic [31:0] a, b;
        c = 4'($urandom_range(15));
        if ($urandom_range(3) == 0) c = ALU_DIV;
        a = $urandom;
        b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
        return ref_op(c, a, b);
    endfunction

    task automatic model_reset();
        busy = 1'b0; last_m = 1'b1; owner_m = 0; hs_cyc = 0; cyc_now = 0;
        rsp_cnt = 0; resp_seen = 1'b0; drop = 2'b00;
        m_a = '0; m_b = '0; m_ctrl = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Called mid-cycle: compares DUT outputs with the model, then advances the model across the coming edge.
    task automatic eval_cycle();
        logic [1:0] exp_rdy, exp_rv;
        int g;
        exp_rdy = 2'b00; exp_rv = 2'b00; g = -1;
        if (!busy) begin
            if (req_valid == 2'b11)  g = last_m ? 0 : 1;
            else if (req_valid[0])   g = 0;
            else if (req_valid[1])   g = 1;
            if (g >= 0) exp_rdy[g] = 1'b1;
        end else if (cyc_now >= hs_cyc + 2) begin
            exp_rv[owner_m] = 1'b1;
        end
        check("req_ready", req_ready, exp_rdy);
        check("resp_valid", resp_valid, exp_rv);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", alu_ctrl, m_ctrl);
        if (exp_rv != 2'b00) begin
            check("resp_result", resp_result, inflight.res);
            check("resp_zero", resp_zero, inflight.zero);
            check("resp_err", resp_err, inflight.err);
            resp_seen = 1'b1;
            if (resp_ready[owner_m]) begin
                busy = 1'b0;
                rsp_cnt = 0;
            end else begin
                rsp_cnt++;
            end
        end
        if (g >= 0) begin
            busy = 1'b1; owner_m = g; last_m = (g == 1); hs_cyc = cyc_now;
            inflight = (g == 1) ? q1.pop_front() : q0.pop_front();
            m_a = inflight.a; m_b = inflight.b; m_ctrl = inflight.ctrl;
            drop[g] = 1'b1;
        end
        cyc_now++;
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: owner 0 stalls 5 RESP cycles; 3: stop in RESP
    task automatic run_engine(input int max_cycles, input int mode);
        int cyc;
        cyc = 0;
        resp_seen = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0 || busy || req_valid != 2'b00) && cyc < max_cycles
               && !(mode == 3 && resp_seen)) begin
            for (int r = 0; r < 2; r++) begin
                if (drop[r]) begin
                    req_valid[r] = 1'b0;
                    drop[r] = 1'b0;
                end
            end
            if (!req_valid[0]) begin
                req_a0 = $urandom; req_b0 = $urandom; req_ctrl0 = 4'($urandom_range(15));
                if (q0.size() != 0 && (mode != 1 || $urandom_range(3) != 0)) begin
                    req_valid[0] = 1'b1;
                    req_a0 = q0[0].a; req_b0 = q0[0].b; req_ctrl0 = q0[0].ctrl;
                end
            end
            if (!req_valid[1]) begin
                req_a1 = $urandom; req_b1 = $urandom; req_ctrl1 = 4'($urandom_range(15));
                if (q1.size() != 0 && (mode != 1 || $urandom_range(3) != 0)) begin
                    req_valid[1] = 1'b1;
                    req_a1 = q1[0].a; req_b1 = q1[0].b; req_ctrl1 = q1[0].ctrl;
                end
            end
            case (mode)
                1:       resp_ready = 2'($urandom_range(3));
                2:       resp_ready = {1'b1, (rsp_cnt >= 5)};
                3:       resp_ready = 2'b10;
                default: resp_ready = 2'b11;
            endcase
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
            cyc++;
        end
        if (mode != 3) check("drain", 64'(q0.size() + q1.size() + int'(busy)), 64'd0);
        else           check("reached_resp", 64'(resp_seen), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset(2);

        // Reset state and combinational arbitration from reset
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_zero", resp_zero, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", alu_ctrl, 4'd0);
        check("rst_req_ready_none", req_ready, 2'b00);
        req_valid = 2'b10; #1;
        check("rst_req_ready_single1", req_ready, 2'b10);
        req_valid = 2'b11; #1;
        check("rst_req_ready_tie", req_ready, 2'b01);
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Single op
        q0.push_back(mk_op(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0));
        run_engine(20, 0);

        // Contention out of reset, then alternation
        do_reset(1);
        q0.push_back(mk_op(ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0));
        q1.push_back(mk_op(ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0));
        q0.push_back(mk_op(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0));
        q1.push_back(mk_op(ALU_XOR, 32'd3, 32'd5, 32'd6, 1'b0, 1'b0));
        q0.push_back(mk_op(ALU_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 1'b1, 1'b0));
        q1.push_back(mk_op(ALU_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0));
        run_engine(60, 0);

        // Divide trap and a normal divide
        q1.push_back(mk_op(ALU_DIV, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1));
        q1.push_back(mk_op(ALU_DIV, 32'd10, 32'd2, 32'd5, 1'b0, 1'b0));
        run_engine(30, 0);

        // Shift / SLT / unknown opcode (falls back to add)
        q0.push_back(mk_op(ALU_SRA, 32'h8000_0000, 32'h0000_0100, 32'hF800_0000, 1'b0, 1'b0));
        q1.push_back(mk_op(ALU_SLT, 32'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0));
        q0.push_back(mk_op(4'b1111, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0));
        run_engine(40, 0);

        // Backpressure: owner 0 stalls 5 cycles while requester 1 waits
        do_reset(1);
        q0.push_back(mk_op(ALU_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0));
        q1.push_back(mk_op(ALU_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0));
        run_engine(40, 2);

        // Reset in the middle of RESP aborts the response and restores the tie-break
        q0.push_back(mk_op(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0));
        run_engine(20, 3);
        do_reset(1);
        @(negedge clk);
        check("abort_resp_valid", resp_valid, 2'b00);
        check("abort_resp_result", resp_result, 32'd0);
        check("abort_resp_err", resp_err, 1'b0);
        check("abort_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        q0.push_back(mk_op(ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0));
        q1.push_back(mk_op(ALU_SLL, 32'd1, 32'h0000_0140, 32'd32, 1'b0, 1'b0));
        run_engine(40, 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        run_engine(6000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
